// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared state encoding and default widths for dmem_responder
package dmem_responder_pkg;

  localparam int DEF_AW         = 16;
  localparam int DEF_DW         = 16;
  localparam int DEF_DEPTH_LOG2 = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - per-core data-port bundle between cores and the shared responder
interface dmem_responder_if
  import dmem_responder_pkg::*;
#(
  parameter int NCORES = 4,
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW
) ();

  logic [NCORES-1:0]    MEMREAD;
  logic [NCORES-1:0]    MEMWR;
  logic [NCORES*AW-1:0] DMADDR;
  logic [NCORES*DW-1:0] DOUT;
  logic [NCORES*DW-1:0] DIN;
  logic [NCORES-1:0]    MEMRDY;
  logic                 BUSY;

  modport master (
    output MEMREAD, MEMWR, DMADDR, DOUT,
    input  DIN, MEMRDY, BUSY
  );

  modport slave (
    input  MEMREAD, MEMWR, DMADDR, DOUT,
    output DIN, MEMRDY, BUSY
  );

endinterface

// File: rtl/dmem_responder_rr_arbiter.sv
// rtl/dmem_responder_rr_arbiter.sv - combinational round-robin pick: first requester at or after ptr
module rr_arbiter #(
  parameter  int NCORES = 4,
  localparam int PW     = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input  logic [NCORES-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [PW-1:0]     grant,
  output logic              any_req
);

  localparam logic [PW:0] NC = (PW+1)'(NCORES);

  logic [NCORES-1:0] rot;
  logic [PW-1:0]     off;
  logic [PW:0]       sum;

  // Rotate so ptr lands at bit 0, find the lowest set bit, then rotate the index back.
  always_comb begin
    rot = NCORES'({req, req} >> ptr);
    off = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NC) sum = sum - NC;
    grant   = sum[PW-1:0];
    any_req = |req;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - shared data memory serving NCORES cores, one access per 3 cycles
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter  int NCORES     = 4,
  parameter  int AW         = DEF_AW,
  parameter  int DW         = DEF_DW,
  parameter  int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  localparam int PW         = (NCORES > 1) ? $clog2(NCORES) : 1
) (
  input logic             clk,
  input logic             rst,
  dmem_responder_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                state, state_nx;
  logic [PW-1:0]         rr_ptr, gnt, g_q;
  logic                  any_req, op_wr;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [DW-1:0]         wdata_q;
  logic [NCORES-1:0]     req, memrdy;
  logic [NCORES*DW-1:0]  din_q;
  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] core_addr [NCORES];
  logic [DW-1:0]         core_data [NCORES];
  logic                  unused_addr_bits;

  assign req = bus.MEMREAD | bus.MEMWR;

  // Upper address bits are dropped so every core address wraps modulo DEPTH.
  for (genvar i = 0; i < NCORES; i++) begin : g_core
    assign core_addr[i] = bus.DMADDR[i*AW +: DEPTH_LOG2];
    assign core_data[i] = bus.DOUT[i*DW +: DW];
  end
  assign unused_addr_bits = ^bus.DMADDR;

  rr_arbiter #(.NCORES(NCORES)) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .grant   (gnt),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    memrdy   = '0;
    unique case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE: begin
        state_nx    = IDLE;
        memrdy[g_q] = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      g_q     <= '0;
      op_wr   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        g_q     <= gnt;
        op_wr   <= bus.MEMWR[gnt];
        addr_q  <= core_addr[gnt];
        wdata_q <= core_data[gnt];
      end
      if (state == ACCESS && !op_wr) begin
        for (int i = 0; i < NCORES; i++) begin
          if (g_q == PW'(i)) din_q[i*DW +: DW] <= mem[addr_q];
        end
      end
      if (state == DONE) begin
        rr_ptr <= (g_q == PW'(NCORES - 1)) ? '0 : g_q + 1'b1;
      end
    end
  end

  // RAM has no reset; a write is dropped if reset lands on its ACCESS edge.
  always_ff @(posedge clk) begin
    if (!rst && state == ACCESS && op_wr) mem[addr_q] <= wdata_q;
  end

  assign bus.DIN    = din_q;
  assign bus.MEMRDY = memrdy;
  assign bus.BUSY   = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed and randomized checks of dmem_responder against a transaction model
module tb_dmem_responder;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DL = 10;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if #(.NCORES(N), .AW(AW), .DW(DW)) bus ();

  dmem_responder #(.NCORES(N), .AW(AW), .DW(DW), .DEPTH_LOG2(DL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Transaction-level model: memory words, last read per core, round-robin start.
  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] dm [N];
  int            ptr_m;
  int            wl [$];

  bit            rq_rd [N];
  bit            rq_wr [N];
  logic [AW-1:0] rq_a  [N];
  logic [DW-1:0] rq_d  [N];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] din_model();
    logic [N*DW-1:0] p;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = dm[i];
    return p;
  endfunction

  task automatic set_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rq_rd[c] = rd;
    rq_wr[c] = wr;
    rq_a[c]  = a;
    rq_d[c]  = d;
  endtask

  task automatic apply_reqs(input bit [N-1:0] live);
    for (int i = 0; i < N; i++) begin
      bus.MEMREAD[i]          = live[i] & rq_rd[i];
      bus.MEMWR[i]            = live[i] & rq_wr[i];
      bus.DMADDR[i*AW +: AW]  = rq_a[i];
      bus.DOUT[i*DW +: DW]    = rq_d[i];
    end
  endtask

  task automatic model_apply(input int k);
    int a;
    a = int'(rq_a[k]) % DEPTH;
    ptr_m = (k + 1) % N;
    if (rq_wr[k]) begin
      mm[a] = rq_d[k];
      wl.push_back(a);
    end else begin
      dm[k] = mm[a];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply_reqs('0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) dm[i] = '0;
    ptr_m = 0;
  endtask

  // Cores in mask request together and drop their request right after their own MEMRDY.
  task automatic run_batch(input bit [N-1:0] mask);
    int       order [$];
    int       seen;
    int       k;
    bit [N-1:0] live;
    for (int j = 0; j < N; j++) begin
      k = (ptr_m + j) % N;
      if (mask[k]) order.push_back(k);
    end
    live = mask;
    apply_reqs(live);
    seen = 0;
    for (int cyc = 0; cyc < 3 * N + 6 && seen < order.size(); cyc++) begin
      @(negedge clk);
      if (bus.MEMRDY != '0) begin
        k = order[seen];
        check("rdy_onehot", bus.MEMRDY, 64'(1) << k);
        check("rdy_cycle", cyc, 2 + 3 * seen);
        check("busy_in_done", bus.BUSY, 1);
        model_apply(k);
        check("din", bus.DIN, din_model());
        live[k] = 1'b0;
        seen++;
        @(posedge clk);
        #1 apply_reqs(live);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("batch_done", seen, order.size());
    @(negedge clk);
    check("idle_after", {bus.BUSY, bus.MEMRDY}, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic abort_in_access(input int c);
    apply_reqs(N'(1) << c);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("busy_access", {bus.BUSY, bus.MEMRDY}, {1'b1, N'(0)});
    rst = 1'b1;
    apply_reqs('0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N; i++) dm[i] = '0;
    ptr_m = 0;
    @(negedge clk);
    check("abort_busy", bus.BUSY, 0);
    check("abort_rdy", bus.MEMRDY, 0);
    check("abort_din", bus.DIN, din_model());
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hits [$];
    bit [N-1:0] mask;
    int a;

    for (int i = 0; i < N; i++) set_req(i, 0, 0, '0, '0);
    rst = 1'b1;
    apply_reqs('0);
    do_reset();
    @(negedge clk);
    check("reset_busy", bus.BUSY, 0);
    check("reset_rdy", bus.MEMRDY, 0);
    check("reset_din", bus.DIN, 0);
    @(posedge clk);
    #1;

    // Single write then read by core 0.
    set_req(0, 0, 1, 16'h0005, 16'hBEEF);
    run_batch(4'b0001);
    set_req(0, 1, 0, 16'h0005, 16'h0000);
    run_batch(4'b0001);
    check("din0_beef", bus.DIN[15:0], 16'hBEEF);

    // Seed distinct words, then all four cores read together from a fresh reset.
    for (int i = 0; i < N; i++) begin
      set_req(i, 0, 1, AW'(16'h0010 + i), DW'(16'hA000 + i));
      run_batch(N'(1) << i);
    end
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, AW'(16'h0010 + i), '0);
    run_batch(4'b1111);
    run_batch(4'b0101);

    // Cross-core coherence.
    set_req(1, 0, 1, 16'h0040, 16'h1234);
    run_batch(4'b0010);
    set_req(3, 1, 0, 16'h0040, 16'h0000);
    run_batch(4'b1000);
    check("din3_coherent", bus.DIN[63:48], 16'h1234);

    // Dual request is a write; address wraps modulo depth.
    set_req(2, 1, 1, 16'h0403, 16'h00AA);
    run_batch(4'b0100);
    set_req(0, 1, 0, 16'h0003, 16'h0000);
    run_batch(4'b0001);
    check("din0_wrap", bus.DIN[15:0], 16'h00AA);

    // Aborted write must not land, aborted read gives no completion.
    set_req(2, 0, 1, 16'h0003, 16'h5555);
    abort_in_access(2);
    set_req(1, 1, 0, 16'h0040, 16'h0000);
    abort_in_access(1);
    set_req(1, 1, 0, 16'h0003, 16'h0000);
    set_req(3, 1, 0, 16'h0010, 16'h0000);
    run_batch(4'b1010);
    check("din1_no_abort_write", bus.DIN[31:16], 16'h00AA);

    // Core 0 holds its read one cycle past MEMRDY and gets served twice.
    $display("[TB] note: core 0 holds MEMREAD past MEMRDY (protocol violation), expecting a second grant");
    set_req(0, 1, 0, 16'h0040, 16'h0000);
    apply_reqs(4'b0001);
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (bus.MEMRDY[0]) hits.push_back(cyc);
      @(posedge clk);
      #1;
      if (cyc == 3) apply_reqs('0);
    end
    check("held_hits", hits.size(), 2);
    if (hits.size() == 2) begin
      check("held_first", hits[0], 2);
      check("held_second", hits[1], 5);
    end
    model_apply(0);
    model_apply(0);
    @(negedge clk);
    check("held_din", bus.DIN, din_model());
    @(posedge clk);
    #1;

    // Randomized batches of mixed reads and writes.
    for (int it = 0; it < 24; it++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) == 1 && wl.size() > 0) begin
          a = wl[$urandom_range(0, wl.size() - 1)];
          set_req(i, 1, 0, AW'(a + ($urandom_range(0, 63) << DL)), DW'($urandom));
        end else begin
          set_req(i, $urandom_range(0, 1) == 1, 1, AW'($urandom), DW'($urandom));
        end
      end
      run_batch(mask);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Shared data-memory responder at the memory side of the core data port, serving NCORES cores.
- Accepts level-held read/write requests on each core's MEMREAD/MEMWR/DMADDR/DOUT, arbitrates round-robin, and performs one access at a time on an internal word-addressed RAM.
- Returns read data on that core's DIN with a one-cycle MEMRDY completion pulse, which the core uses as its stall release.

Parameters:
- NCORES, 4, number of requesting cores (2..8).
- AW, 16, address width per core port.
- DW, 16, data width.
- DEPTH_LOG2, 10, internal RAM depth = 2^DEPTH_LOG2 words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MEMREAD  in  NCORES  per-core read request, held until MEMRDY.
- MEMWR  in  NCORES  per-core write request, held until MEMRDY.
- DMADDR  in  NCORES*AW  per-core address; slice i = [i*AW +: AW].
- DOUT  in  NCORES*DW  per-core write data (core's DOUT).
- DIN  out  NCORES*DW  per-core read data (core's DIN), registered.
- MEMRDY  out  NCORES  per-core one-cycle completion pulse.
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, all DIN slices=0, MEMRDY=0, BUSY=0. RAM contents are not cleared.
- Request of core i: req[i] = MEMREAD[i] | MEMWR[i]. If both are high, the request is treated as a write.
- The address used is DMADDR slice low DEPTH_LOG2 bits; upper bits are ignored, so addresses wrap modulo DEPTH.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req: grant g = first requester at or after rr_ptr (circular).
  - Latch g, op, address and write data; go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - Write: RAM[addr] <= latched data at the end of this cycle.
  - Read: DIN slice g <= RAM[addr] at the end of this cycle.
  - Go to DONE.
- DONE:
  - MEMRDY[g]=1 for exactly this cycle.
  - rr_ptr <= (g+1) mod NCORES.
  - Go to IDLE.
- Latency: request first seen in IDLE at cycle t → MEMRDY pulse in cycle t+2; read data is valid in DIN from cycle t+2.
- Throughput: one access per 3 cycles.
- Requests are sampled only in IDLE. Changes to the address or data of a granted request after the grant are ignored.
- Requester contract: deassert the request at the edge that samples MEMRDY=1. The following IDLE cycle then sees the updated req, so there is no double grant.
- DIN slices hold their last read value. Writes never change DIN. Only the granted slice updates.
- Fairness: a core that is continuously requesting waits at most NCORES-1 other accesses.
- Read-after-write to the same address by another core returns the new data, since accesses are serialized.
- Reset mid-operation:
  - Reset asserted in IDLE or ACCESS: the access is aborted. A write asserted in ACCESS still writes only if rst is low at that edge.
  - MEMRDY is never issued for an aborted access, and rr_ptr returns to 0.
- No request while in ACCESS/DONE is lost; it is seen in the next IDLE.

Decomposition:
- Shared package/header dmem_defs: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and default widths (AW, DW, DEPTH_LOG2).
- One natural sub-module: rr_arbiter.
  - Combinational round-robin priority pick.
  - Inputs: req[NCORES], ptr. Outputs: grant index and any_req.
  - Instantiated once; the FSM, latches and RAM stay in dmem_responder.

Test Plan:
- Single write then read, core 0: MEMWR[0]=1, addr 0x0005, data 0xBEEF until MEMRDY → MEMRDY[0] 2 cycles after request. Then MEMREAD[0] addr 0x0005 → DIN0=0xBEEF with MEMRDY[0] pulse.
- Round-robin, all 4 cores read simultaneously from reset: completions in order 0,1,2,3, MEMRDY pulses 3 cycles apart. Then re-requesting core 0 and core 2 → 0 served before 2 because rr_ptr wrapped to 0.
- Cross-core coherence: core 1 writes 0x1234 to 0x0040, core 3 reads 0x0040 after core 1's MEMRDY → DIN3=0x1234. DIN1 is unchanged by the write.
- Address wrap and dual request:
  - Core 2 asserts MEMREAD and MEMWR with addr 0x0403, data 0x00AA → treated as write to word 3.
  - Core 0 then reads 0x0003 → 0x00AA.
- Reset mid-access: assert rst during ACCESS of a read by core 1 → no MEMRDY, DIN1=0, BUSY=0, state IDLE. The first grant after reset goes to the lowest-indexed requester.
- Held request contract: core 0 keeps MEMREAD high one extra cycle after MEMRDY → a second access is granted, proving sampling occurs only in IDLE. The bench flags this as a protocol violation.
